wb_stage: RTL and testbench
===========================

# wb_stage

Parametrised MEM/WB pipeline register and write-back stage for the RV32 core, generalised to XLEN 32 or 64. It captures one instruction per accepted handshake from the memory stage and selects the result from the ALU, the aligned and extended load data, or the link address. It drives the register-file write port with x0 suppression and misaligned-load suppression, and counts retired instructions. The decode stage's register file consumes its outputs on the following clock edge.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- REG_ADDR_W, 5: register index width.
- CNT_W, 64: width of the retire counter.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  memory stage presents an instruction.
- in_ready  out  1  stage can accept: !valid_q || !wb_hold.
- alu_result  in  XLEN  ALU result; for loads, the byte address.
- mem_rdata  in  XLEN  raw, naturally-aligned data-memory word.
- pc_plus4  in  XLEN  link value for JAL/JALR.
- rd  in  REG_ADDR_W  destination register.
- wb_sel  in  2  result source: 00 = ALU, 01 = load, 10 = pc_plus4, 11 = ALU.
- reg_write  in  1  instruction writes rd.
- ld_funct3  in  3  load type, used only when wb_sel = 01.
- wb_hold  in  1  register-file port unavailable; stalls retirement.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  REG_ADDR_W  write address.
- rf_wdata  out  XLEN  write data.
- err_misalign  out  1  single-cycle pulse on retirement of a misaligned load.
- instret  out  CNT_W  number of retired instructions.

## Operation
- Entry register: fields valid_q, alu, rdata, link, rd, sel, we, f3.
- Accept occurs when in_valid && in_ready. On accept, all fields load and valid_q is set to 1.
- Retire occurs when valid_q && !wb_hold. If a retire happens without an accept in the same cycle, valid_q clears.
- Simultaneous accept and retire: the new entry replaces the old one, and valid_q stays 1.
- Load extraction uses off = alu[log2(XLEN/8)-1:0]. The selected byte/half/word is shifted down by off*8.
  - 000 LB: sign-extend 8 bits.
  - 001 LH: sign-extend 16 bits.
  - 010 LW: sign-extend 32 bits when XLEN = 64.
  - 100 LBU: zero-extend 8 bits.
  - 101 LHU: zero-extend 16 bits.
  - 110 LWU: zero-extend 32 bits (XLEN = 64 only).
  - 011 LD: full word (XLEN = 64 only).
  - Any other code, or a 64-bit-only code when XLEN = 32: full word, no extension.
- Misaligned load (wb_sel = 01): halfword with off[0] != 0, word with off[1:0] != 0, or doubleword with off != 0.
- rf_we = valid_q && !wb_hold && we && (rd != 0) && !misaligned.
- rf_waddr = rd and rf_wdata = selected result whenever valid_q = 1. Both are 0 when valid_q = 0.
- err_misalign = retire && sel == 01 && misaligned.
- instret increments by 1 on every retire, including instructions without a write, x0 targets, and misaligned loads. It wraps modulo 2^CNT_W.

## Timing
- Reset (rst_n low, effective immediately without a clock): valid_q = 0, instret = 0, rf_we = 0, rf_waddr = 0, rf_wdata = 0, err_misalign = 0, in_ready = 1.
- Latency: an instruction accepted at edge N drives rf_we, rf_waddr, rf_wdata and err_misalign combinationally in cycle N+1, when wb_hold = 0. The register file writes at edge N+1.
- instret shows the increment after the retire edge.
- Throughput: one instruction per cycle with no bubbles while wb_hold = 0.
- wb_hold high:
  - The entry is held and outputs are frozen, except that rf_we and err_misalign are forced to 0.
  - in_ready = 0 if valid_q = 1.
  - No instret increment.
- Reset asserted mid-hold or mid-transfer: the held entry is discarded and no write occurs.
- in_valid while in_ready = 0: not accepted. The upstream stage holds its inputs stable.

## Test plan
- Reset, then ALU op: alu_result = 0x0000_1234, rd = 5, reg_write = 1, wb_sel = 00 → one cycle later rf_we = 1, rf_waddr = 5, rf_wdata = 0x1234; instret = 1 after the edge.
- Load extraction with XLEN = 32 and mem_rdata = 0x80FF_7F01:
  - LB at off 1 → 0x0000_007F.
  - LB at off 3 → 0xFFFF_FF80.
  - LHU at off 2 → 0x0000_80FF.
  - LH at off 2 → 0xFFFF_80FF.
  - LW at off 0 → 0x80FF_7F01.
- Misaligned LW at off 2, rd = 7 → rf_we = 0, err_misalign = 1 for one cycle, instret increments.
- Write to x0: rd = 0, reg_write = 1, JAL link 0x104 → rf_we = 0, instret increments. Same with rd = 1 → rf_wdata = 0x104.
- Back-to-back stream of 4 instructions with wb_hold high for 2 cycles on the second one:
  - in_ready = 0 during the hold, the second entry is stable, rf_we = 0.
  - All 4 write in order; instret = 4.
- XLEN = 64, mem_rdata = 0x8000_0001_FFFF_FFFE:
  - LW at off 4 → 0xFFFF_FFFF_8000_0001.
  - LWU at off 4 → 0x0000_0000_8000_0001.
  - Assert rst_n low during a hold → rf_we drops immediately, instret = 0.

Source files
------------

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back stage: captures one instruction per handshake,
// selects ALU / aligned load / link result, drives the register-file write port, counts retirements.
module wb_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       alu_result,
  input  logic [XLEN-1:0]       mem_rdata,
  input  logic [XLEN-1:0]       pc_plus4,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [1:0]            wb_sel,
  input  logic                  reg_write,
  input  logic [2:0]            ld_funct3,
  input  logic                  wb_hold,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  err_misalign,
  output logic [CNT_W-1:0]      instret
);

  localparam int OFF_W = $clog2(XLEN / 8);
  localparam bit IS64  = (XLEN == 64);

  logic                  valid_q;
  logic [XLEN-1:0]       alu_q;
  logic [XLEN-1:0]       rdata_q;
  logic [XLEN-1:0]       link_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [1:0]            sel_q;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [CNT_W-1:0]      instret_q;

  logic                  accept;
  logic                  retire;
  logic                  misaligned;
  logic [OFF_W-1:0]      off;
  logic [XLEN-1:0]       shifted;
  logic [XLEN-1:0]       load_val;
  logic [XLEN-1:0]       result;

  assign in_ready = !valid_q || !wb_hold;
  assign accept   = in_valid && in_ready;
  assign retire   = valid_q && !wb_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      alu_q     <= '0;
      rdata_q   <= '0;
      link_q    <= '0;
      rd_q      <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      f3_q      <= '0;
      instret_q <= '0;
    end else begin
      // A same-cycle accept simply overwrites the retiring entry.
      if (accept) begin
        valid_q <= 1'b1;
        alu_q   <= alu_result;
        rdata_q <= mem_rdata;
        link_q  <= pc_plus4;
        rd_q    <= rd;
        sel_q   <= wb_sel;
        we_q    <= reg_write;
        f3_q    <= ld_funct3;
      end else if (retire) begin
        valid_q <= 1'b0;
      end
      if (retire) begin
        instret_q <= instret_q + 1'b1;
      end
    end
  end

  assign off     = alu_q[OFF_W-1:0];
  assign shifted = rdata_q >> {off, 3'b000};

  always_comb begin
    load_val = shifted;
    case (f3_q)
      3'b000:  load_val = XLEN'($signed(shifted[7:0]));
      3'b001:  load_val = XLEN'($signed(shifted[15:0]));
      3'b100:  load_val = XLEN'(shifted[7:0]);
      3'b101:  load_val = XLEN'(shifted[15:0]);
      3'b010:  if (IS64) load_val = XLEN'($signed(shifted[31:0]));
      3'b110:  if (IS64) load_val = XLEN'(shifted[31:0]);
      default: load_val = shifted;
    endcase
  end

  // Codes that only exist on RV64 behave as plain full-word reads on RV32 and never trap.
  always_comb begin
    misaligned = 1'b0;
    if (sel_q == 2'b01) begin
      case (f3_q)
        3'b001, 3'b101: misaligned = off[0];
        3'b010:         misaligned = |off[1:0];
        3'b110:         misaligned = IS64 && (|off[1:0]);
        3'b011:         misaligned = IS64 && (|off);
        default:        misaligned = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (sel_q)
      2'b01:   result = load_val;
      2'b10:   result = link_q;
      default: result = alu_q;
    endcase
  end

  assign rf_we        = retire && we_q && (rd_q != '0) && !misaligned;
  assign rf_waddr     = valid_q ? rd_q : '0;
  assign rf_wdata     = valid_q ? result : '0;
  assign err_misalign = retire && misaligned;
  assign instret      = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: RV32 and RV64 instances share stimulus and are checked every cycle
// against an arithmetic reference model, plus literal expectations for the named scenarios.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        wb_hold = 1'b0;
  logic        reg_write = 1'b0;
  logic [63:0] alu_result = '0;
  logic [63:0] mem_rdata = '0;
  logic [63:0] pc_plus4 = '0;
  logic [4:0]  rd = '0;
  logic [1:0]  wb_sel = '0;
  logic [2:0]  ld_funct3 = '0;

  logic        in_ready32, rf_we32, err32;
  logic [4:0]  waddr32;
  logic [31:0] wdata32;
  logic [63:0] cnt32;
  logic        in_ready64, rf_we64, err64;
  logic [4:0]  waddr64;
  logic [63:0] wdata64;
  logic [63:0] cnt64;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic [4:0] wr_log[$];

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(64)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .alu_result(alu_result[31:0]), .mem_rdata(mem_rdata[31:0]), .pc_plus4(pc_plus4[31:0]),
    .rd(rd), .wb_sel(wb_sel), .reg_write(reg_write), .ld_funct3(ld_funct3), .wb_hold(wb_hold),
    .rf_we(rf_we32), .rf_waddr(waddr32), .rf_wdata(wdata32), .err_misalign(err32), .instret(cnt32)
  );

  wb_stage #(.XLEN(64), .REG_ADDR_W(5), .CNT_W(64)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .alu_result(alu_result), .mem_rdata(mem_rdata), .pc_plus4(pc_plus4),
    .rd(rd), .wb_sel(wb_sel), .reg_write(reg_write), .ld_funct3(ld_funct3), .wb_hold(wb_hold),
    .rf_we(rf_we64), .rf_waddr(waddr64), .rf_wdata(wdata64), .err_misalign(err64), .instret(cnt64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  // Reference model: one pending instruction plus a retire counter.
  typedef struct packed {
    logic        v;
    logic [63:0] alu;
    logic [63:0] rdata;
    logic [63:0] link;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic        we;
    logic [2:0]  f3;
  } entry_t;

  entry_t      m_e = '0;
  logic [63:0] m_cnt = '0;
  logic        m_acc = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_e   <= '0;
      m_cnt <= '0;
      m_acc <= 1'b0;
    end else begin
      m_acc <= in_valid && (!m_e.v || !wb_hold);
      if (m_e.v && !wb_hold) m_cnt <= m_cnt + 64'd1;
      if (in_valid && (!m_e.v || !wb_hold)) begin
        m_e.v     <= 1'b1;
        m_e.alu   <= alu_result;
        m_e.rdata <= mem_rdata;
        m_e.link  <= pc_plus4;
        m_e.rd    <= rd;
        m_e.sel   <= wb_sel;
        m_e.we    <= reg_write;
        m_e.f3    <= ld_funct3;
      end else if (m_e.v && !wb_hold) begin
        m_e.v <= 1'b0;
      end
    end
  end

  function automatic logic [63:0] xmask(input int xlen);
    return (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] sext(input logic [63:0] v, input int bits, input int xlen);
    logic [63:0] r;
    r = v;
    if (r >= (64'd1 << (bits - 1))) r = r - (64'd1 << bits);
    return r & xmask(xlen);
  endfunction

  function automatic int byte_off(input int xlen, input logic [63:0] alu);
    return int'(alu % 64'(xlen / 8));
  endfunction

  function automatic logic [63:0] load_value(input int xlen, input logic [63:0] rdata,
                                             input logic [63:0] alu, input logic [2:0] f3);
    logic [63:0] sh;
    sh = (rdata & xmask(xlen)) >> (8 * byte_off(xlen, alu));
    case (f3)
      3'd0:    return sext(sh & 64'hFF, 8, xlen);
      3'd1:    return sext(sh & 64'hFFFF, 16, xlen);
      3'd4:    return sh & 64'hFF;
      3'd5:    return sh & 64'hFFFF;
      3'd2:    return (xlen == 64) ? sext(sh & 64'hFFFF_FFFF, 32, xlen) : sh;
      3'd6:    return (xlen == 64) ? (sh & 64'hFFFF_FFFF) : sh;
      default: return sh;
    endcase
  endfunction

  function automatic int access_size(input int xlen, input logic [2:0] f3);
    case (f3)
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      3'd6:       return (xlen == 64) ? 4 : 1;
      3'd3:       return (xlen == 64) ? 8 : 1;
      default:    return 1;
    endcase
  endfunction

  task automatic check_dut(input string tag, input int xlen, input logic ready, input logic we,
                           input logic [4:0] waddr, input logic [63:0] wdata, input logic err,
                           input logic [63:0] cnt);
    logic [63:0] res;
    logic        mis;
    logic        ret;
    ret = m_e.v && !wb_hold;
    mis = (m_e.sel == 2'd1) &&
          ((byte_off(xlen, m_e.alu) % access_size(xlen, m_e.f3)) != 0);
    case (m_e.sel)
      2'd1:    res = load_value(xlen, m_e.rdata, m_e.alu, m_e.f3);
      2'd2:    res = m_e.link & xmask(xlen);
      default: res = m_e.alu & xmask(xlen);
    endcase
    chk({tag, ".in_ready"}, 64'(ready), 64'(!m_e.v || !wb_hold));
    chk({tag, ".rf_we"}, 64'(we), 64'(ret && m_e.we && (m_e.rd != 0) && !mis));
    chk({tag, ".rf_waddr"}, 64'(waddr), m_e.v ? 64'(m_e.rd) : 64'd0);
    chk({tag, ".rf_wdata"}, wdata, m_e.v ? res : 64'd0);
    chk({tag, ".err_misalign"}, 64'(err), 64'(ret && mis));
    chk({tag, ".instret"}, cnt, m_cnt);
  endtask

  always @(negedge clk) begin
    check_dut("m32", 32, in_ready32, rf_we32, waddr32, {32'd0, wdata32}, err32, cnt32);
    check_dut("m64", 64, in_ready64, rf_we64, waddr64, wdata64, err64, cnt64);
    if (rf_we32) wr_log.push_back(waddr32);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    wb_hold  = 1'b0;
    rst_n    = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Present one instruction, accept it at the next edge, return with it in the stage.
  task automatic present(input logic [1:0] sel, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] r, input logic [63:0] l, input logic [4:0] d,
                         input logic w);
    wb_sel = sel; ld_funct3 = f3; alu_result = a; mem_rdata = r; pc_plus4 = l;
    rd = d; reg_write = w; in_valid = 1'b1; wb_hold = 1'b0;
    step();
    in_valid = 1'b0;
    #1;
  endtask

  int          offs[5] = '{1, 3, 2, 2, 0};
  logic [2:0]  f3s[5]  = '{3'd0, 3'd0, 3'd5, 3'd1, 3'd2};
  logic [31:0] exps[5] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_80FF, 32'hFFFF_80FF, 32'h80FF_7F01};

  initial begin
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rst.in_ready", 64'(in_ready32), 64'd1);
    chk("rst.rf_we", 64'(rf_we32), 64'd0);
    chk("rst.rf_waddr", 64'(waddr32), 64'd0);
    chk("rst.rf_wdata", 64'(wdata32), 64'd0);
    chk("rst.err", 64'(err32), 64'd0);
    chk("rst.instret", cnt32, 64'd0);

    present(2'b00, 3'd0, 64'h1234, 64'd0, 64'd0, 5'd5, 1'b1);
    chk("alu.rf_we", 64'(rf_we32), 64'd1);
    chk("alu.rf_waddr", 64'(waddr32), 64'd5);
    chk("alu.rf_wdata", 64'(wdata32), 64'h1234);
    step();
    exp_cnt++;
    chk("alu.instret", cnt32, 64'(exp_cnt));

    for (int i = 0; i < 5; i++) begin
      present(2'b01, f3s[i], 64'(offs[i]), 64'h80FF_7F01, 64'd0, 5'd3, 1'b1);
      chk($sformatf("load%0d.rf_wdata", i), 64'(wdata32), 64'(exps[i]));
      chk($sformatf("load%0d.rf_we", i), 64'(rf_we32), 64'd1);
      step();
      exp_cnt++;
    end

    present(2'b01, 3'd2, 64'd2, 64'h80FF_7F01, 64'd0, 5'd7, 1'b1);
    chk("mis.rf_we", 64'(rf_we32), 64'd0);
    chk("mis.err", 64'(err32), 64'd1);
    step();
    exp_cnt++;
    chk("mis.err_after", 64'(err32), 64'd0);
    chk("mis.instret", cnt32, 64'(exp_cnt));

    present(2'b10, 3'd0, 64'd0, 64'd0, 64'h104, 5'd0, 1'b1);
    chk("x0.rf_we", 64'(rf_we32), 64'd0);
    step();
    exp_cnt++;
    present(2'b10, 3'd0, 64'd0, 64'd0, 64'h104, 5'd1, 1'b1);
    chk("x1.rf_we", 64'(rf_we32), 64'd1);
    chk("x1.rf_wdata", 64'(wdata32), 64'h104);
    step();
    exp_cnt++;
    chk("x1.instret", cnt32, 64'(exp_cnt));

    present(2'b01, 3'd2, 64'd4, 64'h8000_0001_FFFF_FFFE, 64'd0, 5'd2, 1'b1);
    chk("lw64.rf_wdata", wdata64, 64'hFFFF_FFFF_8000_0001);
    step();
    present(2'b01, 3'd6, 64'd4, 64'h8000_0001_FFFF_FFFE, 64'd0, 5'd2, 1'b1);
    chk("lwu64.rf_wdata", wdata64, 64'h0000_0000_8000_0001);
    step();

    // Four-instruction stream with a two-cycle hold on the second one.
    do_reset();
    wr_log.delete();
    begin
      int idx = 0;
      for (int k = 0; k < 10; k++) begin
        wb_hold = (k == 2 || k == 3);
        if (idx < 4) begin
          in_valid = 1'b1; wb_sel = 2'b00; reg_write = 1'b1;
          rd = 5'(idx + 1); alu_result = 64'h100 + 64'(idx);
        end else begin
          in_valid = 1'b0;
        end
        #1;
        if (wb_hold) begin
          chk("hold.in_ready", 64'(in_ready32), 64'd0);
          chk("hold.rf_we", 64'(rf_we32), 64'd0);
          chk("hold.rf_waddr", 64'(waddr32), 64'd2);
          chk("hold.rf_wdata", 64'(wdata32), 64'h101);
        end
        step();
        if (in_valid && m_acc) idx++;
      end
    end
    wb_hold = 1'b0;
    chk("stream.instret", cnt32, 64'd4);
    chk("stream.writes", 64'(wr_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < wr_log.size(); i++)
      chk($sformatf("stream.order%0d", i), 64'(wr_log[i]), 64'(i + 1));

    // Reset in the middle of a transfer, then in the middle of a hold.
    present(2'b00, 3'd0, 64'h55, 64'd0, 64'd0, 5'd9, 1'b1);
    chk("rstx.rf_we_before", 64'(rf_we64), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rstx.rf_we", 64'(rf_we64), 64'd0);
    chk("rstx.rf_waddr", 64'(waddr64), 64'd0);
    chk("rstx.instret", cnt64, 64'd0);
    step();
    rst_n = 1'b1;
    present(2'b00, 3'd0, 64'h66, 64'd0, 64'd0, 5'd10, 1'b1);
    wb_hold = 1'b1;
    #1;
    chk("rsth.in_ready", 64'(in_ready64), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("rsth.in_ready_rst", 64'(in_ready64), 64'd1);
    chk("rsth.rf_waddr", 64'(waddr64), 64'd0);
    wb_hold = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rsth.rf_we", 64'(rf_we64), 64'd0);
    step();
    chk("rsth.instret", cnt64, 64'd0);

    // Randomized traffic; an offered but unaccepted instruction is held stable.
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
      if (!(in_valid && !m_acc)) begin
        in_valid   = ($urandom_range(0, 3) != 0);
        alu_result = {$urandom, $urandom};
        mem_rdata  = {$urandom, $urandom};
        pc_plus4   = {$urandom, $urandom};
        rd         = 5'($urandom_range(0, 31));
        wb_sel     = 2'($urandom_range(0, 3));
        reg_write  = 1'($urandom_range(0, 1));
        ld_funct3  = 3'($urandom_range(0, 7));
      end
      wb_hold = ($urandom_range(0, 3) == 0);
      step();
    end
    in_valid = 1'b0;
    wb_hold  = 1'b0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
